wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Parametrised weighted round-robin arbiter. It is the successor to the fixed 4-way round-robin arbiter and generalises it in three ways: N requesters, a per-requester burst weight (consecutive grants per turn), and a hold input for packet-atomic ownership. It sits in front of any shared resource (bus port, memory bank, FIFO write side). With all weights at 1 and hold low, it behaves as a plain round-robin arbiter with a registered grant.

## Interface
- N, default 4: number of requesters, at least 2.
- CW, default 4: width of each weight field. Maximum burst is 2^CW-1.
- IDW, default $clog2(N): width of grant_id.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  request vector. Bit i is requester i.
- weight  input  N*CW  per-requester weight. Field i is bits [i*CW +: CW]. Quasi-static; sampled only when a new owner is selected.
- hold  input  1  while high and the owner's req is high, the owner keeps the grant regardless of credit.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_valid  output  1  OR of grant.
- grant_id  output  IDW  index of the granted requester. Holds its last value when grant_valid is 0.

## Operation
- Internal state:
  - owner index, IDW bits.
  - owner_valid.
  - credit, CW bits: grants remaining after the current one.
- Effective weight: ew(i) = (weight_i == 0) ? 1 : weight_i.
- Evaluated every cycle, result registered at the next edge:
  - KEEP: owner_valid && req[owner] && (hold || credit != 0). The owner is granted again. credit decrements only if credit != 0 (it saturates at 0 under hold).
  - SWITCH: otherwise, pick the first requester with req set, scanning owner+1, owner+2, … with wrap, and ending with owner itself. For requester j found: owner <= j, owner_valid <= 1, credit <= ew(j)-1.
  - IDLE: no req bit is set. grant <= 0, owner_valid <= 0. The owner index is retained as the round-robin pointer.
- If the owner drops req mid-burst, its remaining credit is discarded and arbitration moves on.
- If the sole requester exhausts its credit, it wins the re-scan with reloaded credit, so its grant is continuous.
- After reset the pointer is N-1, which makes requester 0 highest priority on the first arbitration.
- hold with credit exhausted: hold wins (KEEP).
- hold with the owner's req low: hold is ignored (SWITCH or IDLE).

## Timing
- Latency: req sampled at edge k produces grant at edge k+1. There is no combinational path from req to grant.
- Reset values:
  - grant = 0
  - grant_valid = 0
  - grant_id = 0
  - owner = N-1
  - owner_valid = 0
  - credit = 0
- Reset mid-burst: the outputs clear asynchronously on the falling edge of rst_n. The first grant after release follows the post-reset priority (requester 0 first).
- Throughput: one grant per cycle. There are no bubbles on owner change.
- Width rules:
  - credit arithmetic is unsigned CW bits and never underflows.
  - The owner+k scan uses modulo-N arithmetic and must be correct for non-power-of-2 N.

## Structure
- Package wrr_arbiter_pkg holds the eff_weight function (zero maps to 1) and the state-encoding localparams KEEP/SWITCH/IDLE.
- Sub-module wrr_rr_pick: a combinational rotating priority picker. Inputs are req[N] and a start index. Outputs are found and idx. It is instantiated once. The top level holds the owner/credit registers and the next-state logic.

## Test plan
Configuration N=4, CW=4 unless stated. Grants are listed per cycle after reset release.
- All weights 1, hold=0, req=4'b1111 held -> grant 0001, 0010, 0100, 1000, 0001, … and grant_id 0, 1, 2, 3, 0.
- weight0=3, others 1, req=4'b1111 -> 0001, 0001, 0001, 0010, 0100, 1000, 0001×3.
- weight0=3, req=4'b0011. After the first 0001, set req=4'b0010 -> next grant 0010 (credit discarded). Return req to 0011 -> 0001 gets 3 cycles again.
- All weights 1, req=4'b0011, hold=1 while the owner is 0 -> grant 0001 for 5 cycles. Drop hold -> next grant 0010.
- Sole requester and zero weight:
  - req=4'b1000 with weight3=2 -> grant 1000 continuous, no gaps.
  - weight0=weight1=0, req=4'b0011 -> alternates 0001/0010, proving zero weight acts as 1.
  - req=0 -> grant_valid=0 one cycle later.
- Reset mid-burst: weight0=5, req=4'b1111, assert rst_n=0 at cycle 2 -> grant=0 immediately, with no clock edge needed. After release, the first grant is 0001 with a full 5-cycle burst.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
//   arb_op_t            : per-cycle arbitration decision
//   KEEP / SWITCH / IDLE: decision encodings
//   eff_weight()        : maps a zero weight to 1 so every owner gets at least one grant
package wrr_arbiter_pkg;

  typedef logic [1:0] arb_op_t;

  localparam arb_op_t KEEP   = 2'd0;
  localparam arb_op_t SWITCH = 2'd1;
  localparam arb_op_t IDLE   = 2'd2;

  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
//   req         : request vector, bit i is requester i
//   weight      : packed per-requester burst weights, field i = [i*CW +: CW]
//   hold        : keep current owner while it still requests
//   grant       : registered one-hot grant (or zero)
//   grant_valid : OR of grant
//   grant_id    : index of the granted requester, sticky when idle
// Modports: master = requester side, slave = arbiter side.
interface wrr_arbiter_if #(
  parameter int N   = 4,
  parameter int CW  = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic            hold;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;

  modport master (
    output req, weight, hold,
    input  grant, grant_valid, grant_id
  );

  modport slave (
    input  req, weight, hold,
    output grant, grant_valid, grant_id
  );
endinterface

// File: rtl/wrr_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   start : index with highest priority; scan runs start, start+1, ... modulo N
//   found : at least one request bit set
//   idx   : first requesting index in scan order (0 when none)
module wrr_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      // start is always < N, so a single conditional subtract gives modulo N
      // without relying on a power-of-2 wrap.
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst credit and packet hold.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wrr_arbiter_if.slave (req/weight/hold in, grant/grant_valid/grant_id out)
// Each cycle the current owner is either kept (credit left, or hold while it
// still requests), replaced by the next requester after it in rotating order,
// or the arbiter goes idle. The decision is registered: no comb path req->grant.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int CW  = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  wrr_arbiter_if.slave  bus
);

  logic [IDW-1:0] owner_q, owner_nxt;
  logic           owner_vld_q, owner_vld_nxt;
  logic [CW-1:0]  credit_q, credit_nxt;
  logic [N-1:0]   grant_q, grant_nxt;
  logic [IDW-1:0] grant_id_q, grant_id_nxt;

  logic [IDW-1:0] scan_start;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [CW-1:0]  pick_weight;
  logic           keep;
  arb_op_t        op;

  // Scan begins one past the owner so the owner itself is tried last.
  assign scan_start = (owner_q == IDW'(N-1)) ? '0 : owner_q + 1'b1;

  wrr_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (bus.req),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_weight = bus.weight[int'(pick_idx)*CW +: CW];

  // Hold overrides exhausted credit, but only while the owner still requests.
  assign keep = owner_vld_q && bus.req[owner_q] && (bus.hold || (credit_q != '0));

  always_comb begin
    if (keep)            op = KEEP;
    else if (pick_found) op = SWITCH;
    else                 op = IDLE;
  end

  always_comb begin
    owner_nxt     = owner_q;
    owner_vld_nxt = owner_vld_q;
    credit_nxt    = credit_q;
    grant_nxt     = '0;
    grant_id_nxt  = grant_id_q;
    case (op)
      KEEP: begin
        // Saturate at zero: under hold the owner may run past its weight.
        if (credit_q != '0) credit_nxt = credit_q - 1'b1;
        grant_nxt[owner_q] = 1'b1;
        grant_id_nxt       = owner_q;
      end
      SWITCH: begin
        owner_nxt           = pick_idx;
        owner_vld_nxt       = 1'b1;
        credit_nxt          = CW'(eff_weight(32'(pick_weight)) - 32'd1);
        grant_nxt[pick_idx] = 1'b1;
        grant_id_nxt        = pick_idx;
      end
      default: begin
        // Owner index is kept as the round-robin pointer; grant_id stays sticky.
        owner_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= IDW'(N-1);
      owner_vld_q <= 1'b0;
      credit_q    <= '0;
      grant_q     <= '0;
      grant_id_q  <= '0;
    end else begin
      owner_q     <= owner_nxt;
      owner_vld_q <= owner_vld_nxt;
      credit_q    <= credit_nxt;
      grant_q     <= grant_nxt;
      grant_id_q  <= grant_id_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
module tb_wrr_arbiter;

  logic clk;
  logic rst_n;

  wrr_arbiter_if #(.N(4), .CW(4), .IDW(2)) bus ();

  wrr_arbiter #(.N(4), .CW(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] weight;
    logic        hold;
    logic [3:0]  g;
    logic [1:0]  id;
    logic        v;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] r, input logic [15:0] w, input logic h,
                              input logic [3:0] g, input logic [1:0] id, input logic v);
    vec_t e;
    e.req = r; e.weight = w; e.hold = h; e.g = g; e.id = id; e.v = v;
    vq.push_back(e);
  endfunction

  task automatic do_reset(input logic [15:0] w);
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.weight = w;
    bus.hold   = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_valid", 32'(bus.grant_valid), 32'h0);
    check("rst_id", 32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      bus.req    = vq[i].req;
      bus.weight = vq[i].weight;
      bus.hold   = vq[i].hold;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].grant", name, i), 32'(bus.grant), 32'(vq[i].g));
      check($sformatf("%s[%0d].valid", name, i), 32'(bus.grant_valid), 32'(vq[i].v));
      check($sformatf("%s[%0d].id", name, i), 32'(bus.grant_id), 32'(vq[i].id));
    end
    vq.delete();
  endtask

  localparam logic [15:0] W1111 = 16'h1111;
  localparam logic [15:0] W0_3  = 16'h1113;
  localparam logic [15:0] W3_2  = 16'h2111;
  localparam logic [15:0] W01_0 = 16'h1100;
  localparam logic [15:0] W0_5  = 16'h1115;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.req = '0; bus.weight = W1111; bus.hold = 1'b0;

    // Plain round robin
    do_reset(W1111);
    add(4'hF, W1111, 0, 4'b0001, 0, 1);
    add(4'hF, W1111, 0, 4'b0010, 1, 1);
    add(4'hF, W1111, 0, 4'b0100, 2, 1);
    add(4'hF, W1111, 0, 4'b1000, 3, 1);
    add(4'hF, W1111, 0, 4'b0001, 0, 1);
    run_table("rr");

    // Weight 3 on requester 0
    do_reset(W0_3);
    for (int i = 0; i < 3; i++) add(4'hF, W0_3, 0, 4'b0001, 0, 1);
    add(4'hF, W0_3, 0, 4'b0010, 1, 1);
    add(4'hF, W0_3, 0, 4'b0100, 2, 1);
    add(4'hF, W0_3, 0, 4'b1000, 3, 1);
    for (int i = 0; i < 3; i++) add(4'hF, W0_3, 0, 4'b0001, 0, 1);
    add(4'hF, W0_3, 0, 4'b0010, 1, 1);
    run_table("wt3");

    // Owner drops request mid-burst
    do_reset(W0_3);
    add(4'b0011, W0_3, 0, 4'b0001, 0, 1);
    add(4'b0010, W0_3, 0, 4'b0010, 1, 1);
    for (int i = 0; i < 3; i++) add(4'b0011, W0_3, 0, 4'b0001, 0, 1);
    add(4'b0011, W0_3, 0, 4'b0010, 1, 1);
    run_table("drop");

    // Hold keeps owner past its credit
    do_reset(W1111);
    for (int i = 0; i < 5; i++) add(4'b0011, W1111, 1, 4'b0001, 0, 1);
    add(4'b0011, W1111, 0, 4'b0010, 1, 1);
    add(4'b0011, W1111, 0, 4'b0001, 0, 1);
    run_table("hold");

    // Hold ignored when owner does not request
    do_reset(W1111);
    add(4'b0011, W1111, 1, 4'b0001, 0, 1);
    add(4'b0010, W1111, 1, 4'b0010, 1, 1);
    run_table("holdx");

    // Sole requester with weight 2: continuous grant
    do_reset(W3_2);
    for (int i = 0; i < 5; i++) add(4'b1000, W3_2, 0, 4'b1000, 3, 1);
    run_table("sole");

    // Zero weight behaves as 1, then idle with sticky grant_id
    do_reset(W01_0);
    add(4'b0011, W01_0, 0, 4'b0001, 0, 1);
    add(4'b0011, W01_0, 0, 4'b0010, 1, 1);
    add(4'b0011, W01_0, 0, 4'b0001, 0, 1);
    add(4'b0011, W01_0, 0, 4'b0010, 1, 1);
    add(4'b0000, W01_0, 0, 4'b0000, 1, 0);
    add(4'b0000, W01_0, 0, 4'b0000, 1, 0);
    add(4'b0100, W01_0, 0, 4'b0100, 2, 1);
    run_table("zw");

    // Asynchronous reset in the middle of a burst
    do_reset(W0_5);
    add(4'hF, W0_5, 0, 4'b0001, 0, 1);
    add(4'hF, W0_5, 0, 4'b0001, 0, 1);
    run_table("pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant), 32'h0);
    check("async_valid", 32'(bus.grant_valid), 32'h0);
    check("async_id", 32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    check("inrst_grant", 32'(bus.grant), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) add(4'hF, W0_5, 0, 4'b0001, 0, 1);
    add(4'hF, W0_5, 0, 4'b0010, 1, 1);
    run_table("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
